// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states and op helpers.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between pipeline control and the multiply/divide unit.
interface mdu_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, cancel, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, cancel, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_arith.sv
// Combinational product and quotient/remainder; wr=0 flags a zero divisor so HI/LO are left alone.
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             wr
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]   b_safe, a_mag, b_mag, q_u, r_u, q_m, r_m, q_s, r_s;
  logic               div_zero, a_neg, b_neg;

  always_comb begin
    prod_u   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    // Low 2*WIDTH bits of the sign-extended product equal the signed product.
    prod_s   = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};

    div_zero = (b == '0);
    b_safe   = div_zero ? ONE : b;
    q_u      = a / b_safe;
    r_u      = a % b_safe;

    // Signed divide on magnitudes; MIN/-1 falls out as MIN with remainder 0.
    a_neg    = a[WIDTH-1];
    b_neg    = b[WIDTH-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = div_zero ? ONE : (b_neg ? -b : b);
    q_m      = a_mag / b_mag;
    r_m      = a_mag % b_mag;
    q_s      = (a_neg ^ b_neg) ? -q_m : q_m;
    r_s      = a_neg ? -r_m : r_m;

    hi = '0;
    lo = '0;
    case (op)
      MDU_MULT:  {hi, lo} = prod_s;
      MDU_MULTU: {hi, lo} = prod_u;
      MDU_DIV:   begin hi = r_s; lo = q_s; end
      MDU_DIVU:  begin hi = r_u; lo = q_u; end
      default:   ;
    endcase
    wr = !(is_div(op) && div_zero);
  end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers, busy stall and cancel.
//   state | meaning
//   IDLE  | no mul/div in flight; accepts MULT/DIV and MTHI/MTLO
//   RUN   | result staged, counter running down to completion
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  mdu_state_e       state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] hi_q, lo_q, hi_stage, lo_stage, res_hi, res_lo;
  logic             stage_wr, res_wr, done_q;
  logic             accept, mt_wr, finish, flush;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .op (bus.op),
    .a  (bus.a),
    .b  (bus.b),
    .hi (res_hi),
    .lo (res_lo),
    .wr (res_wr)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    mt_wr     = 1'b0;
    finish    = 1'b0;
    flush     = 1'b0;
    case (state)
      IDLE: begin
        // cancel masks any request in the same cycle, MTxx included
        if (bus.start && !bus.cancel) begin
          if (is_muldiv(bus.op)) begin
            accept    = 1'b1;
            state_nxt = RUN;
            cnt_nxt   = is_div(bus.op) ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
          end else if (bus.op == MDU_MTHI || bus.op == MDU_MTLO) begin
            mt_wr = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.cancel) begin
          flush     = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_stage <= '0;
      lo_stage <= '0;
      stage_wr <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      done_q <= finish;
      if (accept) begin
        hi_stage <= res_hi;
        lo_stage <= res_lo;
        stage_wr <= res_wr;
      end else if (flush || finish) begin
        hi_stage <= '0;
        lo_stage <= '0;
        stage_wr <= 1'b0;
      end
      if (finish && stage_wr) begin
        hi_q <= hi_stage;
        lo_q <= lo_stage;
      end
      if (mt_wr) begin
        if (bus.op == MDU_MTHI) hi_q <= bus.a;
        else                    lo_q <= bus.a;
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed vector bench for mdu_unit: table of mul/div results plus hand-written corner sequences.
module tb_mdu_unit;
  import mdu_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] model_hi, model_lo;

  mdu_if #(.WIDTH(32)) bus ();

  mdu_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [31:0] a, b, hi, lo;
    int         n;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // inject > 0 drives a MULT request in that busy cycle, which must be ignored.
  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int n, input int inject);
    int cnt;
    cnt = 0;
    issue(op, a, b);
    while (bus.busy && cnt < 100) begin
      cnt++;
      check({nm, "_hold_done"}, bus.done, 0);
      check({nm, "_hold_hi"}, bus.hi, model_hi);
      check({nm, "_hold_lo"}, bus.lo, model_lo);
      if (cnt == inject) begin
        bus.start = 1'b1;
        bus.op    = MDU_MULT;
        bus.a     = 32'd3;
        bus.b     = 32'd3;
      end
      @(negedge clk);
      bus.start = 1'b0;
    end
    check({nm, "_cycles"}, cnt, n);
    check({nm, "_done"}, bus.done, 1);
    check({nm, "_hi"}, bus.hi, eh);
    check({nm, "_lo"}, bus.lo, el);
    model_hi = eh;
    model_lo = el;
    @(negedge clk);
    check({nm, "_done_clr"}, bus.done, 0);
    check({nm, "_idle"}, bus.busy, 0);
  endtask

  initial begin
    vecs[0] = '{"mult_neg1x2",  MDU_MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs[1] = '{"multu_maxx2",  MDU_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2] = '{"div_m7_2",     MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{"div_ovf",      MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[4] = '{"mult_maxpos",  MDU_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};
    vecs[5] = '{"div_7_m2",     MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[6] = '{"divu_max_16",  MDU_DIVU,  32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF, 10};
    vecs[7] = '{"mult_m3x5",    MDU_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
    vecs[8] = '{"multu_big",    MDU_MULTU, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};

    reset      = 1'b0;
    bus.start  = 1'b0;
    bus.op     = 3'd0;
    bus.a      = '0;
    bus.b      = '0;
    bus.cancel = 1'b0;
    model_hi   = '0;
    model_lo   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    reset = 1'b1;

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].n, 0);

    // MTHI/MTLO, then divide by zero leaves them intact
    issue(MDU_MTHI, 32'h1234, 32'd0);
    check("mthi_hi", bus.hi, 32'h1234);
    check("mthi_busy", bus.busy, 0);
    check("mthi_done", bus.done, 0);
    issue(MDU_MTLO, 32'h5678, 32'd0);
    check("mtlo_lo", bus.lo, 32'h5678);
    check("mtlo_hi", bus.hi, 32'h1234);
    model_hi = 32'h1234;
    model_lo = 32'h5678;
    run_op("divu_by0", MDU_DIVU, 32'd7, 32'd0, 32'h1234, 32'h5678, 10, 0);

    // Start while busy is ignored
    run_op("divu_inject", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 10, 3);

    // Reserved op and cancel in IDLE do nothing
    issue(3'd6, 32'hDEAD, 32'hBEEF);
    check("rsvd_busy", bus.busy, 0);
    check("rsvd_hi", bus.hi, 32'd2);
    @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel_idle_busy", bus.busy, 0);
    check("cancel_idle_lo", bus.lo, 32'd14);

    // cancel together with start: neither MULT nor MTHI is taken
    @(negedge clk);
    bus.start = 1'b1; bus.cancel = 1'b1; bus.op = MDU_MULT; bus.a = 32'd9; bus.b = 32'd9;
    @(negedge clk);
    check("cancel_start_busy", bus.busy, 0);
    bus.op = MDU_MTHI;
    @(negedge clk);
    bus.start = 1'b0; bus.cancel = 1'b0;
    check("cancel_mthi_hi", bus.hi, 32'd2);

    // cancel in busy cycle 4
    issue(MDU_MULT, 32'd3, 32'd4);
    repeat (3) @(negedge clk);
    check("cancel_pre_busy", bus.busy, 1);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel_busy", bus.busy, 0);
    check("cancel_done", bus.done, 0);
    check("cancel_hi", bus.hi, 32'd2);
    check("cancel_lo", bus.lo, 32'd14);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("cancel_no_done", bus.done, 0);
    end
    check("cancel_lo_after", bus.lo, 32'd14);

    // Start on the completion edge is ignored
    issue(MDU_MULT, 32'd2, 32'd3);
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.op = MDU_MULTU; bus.a = 32'd5; bus.b = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    check("cmpl_start_busy", bus.busy, 0);
    check("cmpl_start_done", bus.done, 1);
    check("cmpl_start_lo", bus.lo, 32'd6);
    check("cmpl_start_hi", bus.hi, 32'd0);
    @(negedge clk);
    check("cmpl_start_ignored", bus.busy, 0);

    // Asynchronous reset mid-operation
    issue(MDU_DIV, 32'd50, 32'd5);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_hi", bus.hi, 0);
    check("arst_lo", bus.lo, 0);
    check("arst_done", bus.done, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("arst_no_done", bus.done, 0);
      check("arst_no_busy", bus.busy, 0);
    end
    check("arst_lo_after", bus.lo, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit that extends the single-cycle datapath with HI/LO state. It serves MULT, MULTU, DIV, DIVU, MTHI and MTLO; MFHI/MFLO read the hi/lo outputs directly.
- Sits beside the ALU. Operands come from the rs/rt register values.
- Exposes busy so control can stall any later MDU instruction or MFHI/MFLO.
- Width and latencies are parametrised.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_CYCLES, 5, busy cycles for MULT/MULTU (must be at least 1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be at least 1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; reset==0 clears all state immediately.
- start  in  1  one-cycle request strobe qualified by op.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are reserved.
- a  in  WIDTH  rs value (dividend / multiplicand / MTxx data).
- b  in  WIDTH  rt value (divisor / multiplier).
- cancel  in  1  abort the in-flight operation (exception flush).
- busy  out  1  a multiply/divide is in flight.
- done  out  1  one-cycle pulse in the cycle HI/LO take a mul/div result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset==0, asynchronous):
  - hi=0, lo=0, busy=0, done=0.
  - Counter and staging registers are cleared; the FSM goes to IDLE.
  - An operation in flight is discarded.
- FSM states: IDLE and RUN.
  - IDLE to RUN: at an edge with start=1 and op in 0..3.
  - RUN to IDLE: at the edge where the counter reaches 0, or at any edge with cancel=1.
- Acceptance and latency:
  - On acceptance the result is computed from a and b sampled at that edge and held in staging registers.
  - The counter loads N-1, where N is MUL_CYCLES or DIV_CYCLES.
  - busy=1 for exactly N cycles after the accepting edge.
  - At the edge that ends the last busy cycle, hi/lo load the staged result and done=1 for one cycle.
  - hi/lo never change while busy=1.
- MTHI/MTLO:
  - Accepted only in IDLE.
  - At that edge, hi<=a (MTHI) or lo<=a (MTLO).
  - busy and done stay 0.
- Ignored requests (no state change):
  - start while busy=1, whatever the op.
  - Reserved op 6 or 7.
- Arithmetic:
  - MULT: signed 2*WIDTH product.
  - MULTU: unsigned 2*WIDTH product.
  - For both multiplies, hi = upper WIDTH bits and lo = lower WIDTH bits.
  - DIV: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Boundary cases:
  - Divide by zero (b==0, DIV or DIVU): the operation is still accepted and busy runs the full DIV_CYCLES, but at completion hi/lo stay unchanged and done still pulses.
  - Signed overflow (DIV with a = most negative value and b = all-ones): lo = most negative value, hi=0.
  - cancel=1 while busy: at the next edge busy=0, done=0, hi/lo unchanged, staging registers discarded.
  - cancel=1 in IDLE has no effect.
  - cancel and start at the same edge: cancel wins, and the start is not accepted even from IDLE.
  - Completion edge with start=1: the start is ignored, because busy is still 1 in that cycle. Control re-issues the request the next cycle.

Decomposition:
- Shared package mdu_pkg holds:
  - the op encodings MDU_MULT..MDU_MTLO as 3-bit constants;
  - the FSM state constants IDLE and RUN.
  - The datapath control and the MUX select for MFHI/MFLO reuse these constants.
- Optional sub-module mdu_arith: combinational signed/unsigned product and quotient/remainder, including the zero-divisor and overflow handling.
- The FSM, counter and HI/LO registers stay in mdu_unit.

Test Plan:
1. MULT with a=0xFFFFFFFF, b=2: busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE, with done pulsing once.
2. MULTU with a=0xFFFFFFFF, b=2: after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
3. DIV with a=0xFFFFFFF9 (-7), b=2: busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
4. DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
5. DIVU 7/0 after MTHI 0x1234 and MTLO 0x5678: after 10 cycles hi=0x1234, lo=0x5678, and done=1.
6. DIVU 100/7, then a MULT start at cycle 3 of busy: the MULT is ignored, and hi=2, lo=14 arrive at cycle 10.
7. cancel at busy cycle 4: busy=0 at the next edge and hi/lo keep their previous values.
8. reset=0 mid-operation: all outputs go to 0 immediately, and no done pulse follows after release.
